// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the register write-back path
//
// Purpose: common definitions for the write-back queue, the register unit and
// the issue logic, so that all of them agree on entry layout and widths.
//   XLEN      data width of one register
//   REG_AW    register address width (32 registers)
//   WB_DEPTH  default write-back FIFO depth (power of two, >= 2)
//   wb_entry_t  one pending register write {rd, data}
//   rd_is_x0    true for the hard-wired zero register

package wb_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic rd_is_x0(input logic [REG_AW-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order storage for pending register writes
//
// Purpose: small circular FIFO holding pending register writes, with an
// age-ordered view of every slot for the forwarding scan.
// Ports:
//   clk, resetN   clock, asynchronous active-low reset
//   enq           write enq_entry at the tail this cycle (caller guarantees space)
//   enq_entry     entry to write
//   deq           retire the head entry this cycle (caller guarantees count != 0)
//   head          entry at the head pointer (meaningful only when count != 0)
//   count         occupied entries; sole full/empty discriminator
//   view_valid    bit k set when the k-th oldest slot holds a pending entry
//   view_entry    k-th oldest slot contents (index 0 = head, higher = younger)

module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enq,
  input  wb_entry_t             enq_entry,
  input  logic                  deq,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  output logic [DEPTH-1:0]      view_valid,
  output wb_entry_t [DEPTH-1:0] view_entry
);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Storage needs no reset: validity is derived from count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Rotate the slots so the consumer sees them oldest-first.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      view_entry[k] = mem[rd_ptr + PW'(k)];
      view_valid[k] = CW'(k) < count;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - arbitrated write-back queue with operand forwarding
//
// Purpose: accepts ALU and load results over valid/ready, buffers them in order
// and drains one per cycle into the register unit write port. Pending results
// are visible to operand reads through a youngest-match forwarding lookup.
// Ports:
//   clk, resetN                     clock, asynchronous active-low reset
//   aluValid/aluReady/aluRd/aluData ALU result handshake (lower priority)
//   memValid/memReady/memRd/memData load result handshake (higher priority)
//   rfHold                          1 = register unit must not be written
//   rfRd/rfWriteEnable/rfData       register unit write port (head entry)
//   fwdRs1/fwdRs2                   operand addresses to look up
//   fwdHit1/fwdHit2                 a pending write exists for the operand
//   fwdData1/fwdData2               data of the youngest matching pending write
//   count                           occupied entries

module writeback_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [REG_AW-1:0] aluRd,
  input  logic [XLEN-1:0]   aluData,
  input  logic              memValid,
  output logic              memReady,
  input  logic [REG_AW-1:0] memRd,
  input  logic [XLEN-1:0]   memData,
  input  logic              rfHold,
  output logic [REG_AW-1:0] rfRd,
  output logic              rfWriteEnable,
  output logic [XLEN-1:0]   rfData,
  input  logic [REG_AW-1:0] fwdRs1,
  input  logic [REG_AW-1:0] fwdRs2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [XLEN-1:0]   fwdData1,
  output logic [XLEN-1:0]   fwdData2,
  output logic [CW-1:0]     count
);

  logic                  run;
  logic                  deq;
  logic                  space;
  logic                  mem_fire;
  logic                  alu_fire;
  logic                  enq;
  wb_entry_t             in_entry;
  wb_entry_t             head;
  logic [DEPTH-1:0]      view_valid;
  wb_entry_t [DEPTH-1:0] view_entry;

  // Readys are held low while in reset and for the first edge after release,
  // so nothing is accepted while the queue is being cleared.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_comb begin
    deq   = (count != '0) && !rfHold;
    // A dequeue in the same cycle frees a slot, so a full queue still accepts.
    space = (count < CW'(DEPTH)) || deq;

    memReady = run && space;
    aluReady = run && space && !memValid;

    mem_fire = memValid && memReady;
    alu_fire = aluValid && aluReady;

    if (mem_fire) begin
      in_entry.rd   = memRd;
      in_entry.data = memData;
    end else begin
      in_entry.rd   = aluRd;
      in_entry.data = aluData;
    end

    // Writes to x0 complete their handshake but are dropped here.
    enq = (mem_fire || alu_fire) && !rd_is_x0(in_entry.rd);

    rfWriteEnable = deq;
    if (count != '0) begin
      rfRd   = head.rd;
      rfData = head.data;
    end else begin
      rfRd   = '0;
      rfData = '0;
    end
  end

  // Oldest-to-youngest scan; later matches overwrite earlier ones, leaving the
  // youngest. The head is included even while it is being written.
  always_comb begin
    fwdHit1  = 1'b0;
    fwdData1 = '0;
    fwdHit2  = 1'b0;
    fwdData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (view_valid[k] && !rd_is_x0(fwdRs1) && (view_entry[k].rd == fwdRs1)) begin
        fwdHit1  = 1'b1;
        fwdData1 = view_entry[k].data;
      end
      if (view_valid[k] && !rd_is_x0(fwdRs2) && (view_entry[k].rd == fwdRs2)) begin
        fwdHit2  = 1'b1;
        fwdData2 = view_entry[k].data;
      end
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetN     (resetN),
    .enq        (enq),
    .enq_entry  (in_entry),
    .deq        (deq),
    .head       (head),
    .count      (count),
    .view_valid (view_valid),
    .view_entry (view_entry)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue

module tb_writeback_queue;

  logic        clk;
  logic        resetN;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        rfHold;
  logic [4:0]  rfRd;
  logic        rfWriteEnable;
  logic [31:0] rfData;
  logic [4:0]  fwdRs1;
  logic [4:0]  fwdRs2;
  logic        fwdHit1;
  logic        fwdHit2;
  logic [31:0] fwdData1;
  logic [31:0] fwdData2;
  logic [2:0]  count;

  writeback_queue dut (
    .clk           (clk),
    .resetN        (resetN),
    .aluValid      (aluValid),
    .aluReady      (aluReady),
    .aluRd         (aluRd),
    .aluData       (aluData),
    .memValid      (memValid),
    .memReady      (memReady),
    .memRd         (memRd),
    .memData       (memData),
    .rfHold        (rfHold),
    .rfRd          (rfRd),
    .rfWriteEnable (rfWriteEnable),
    .rfData        (rfData),
    .fwdRs1        (fwdRs1),
    .fwdRs2        (fwdRs2),
    .fwdHit1       (fwdHit1),
    .fwdHit2       (fwdHit2),
    .fwdData1      (fwdData1),
    .fwdData2      (fwdData2),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Register unit model: write port sampled mid-cycle, committed at the edge
  // only if reset is not asserted at that edge.
  int   regs [32];
  int   log_rd [$];
  int   log_data [$];
  logic pend_we   = 1'b0;
  int   pend_rd   = 0;
  int   pend_data = 0;

  always @(negedge clk) begin
    pend_we   = rfWriteEnable;
    pend_rd   = int'(rfRd);
    pend_data = int'(rfData);
  end

  always @(posedge clk) begin
    if (pend_we && resetN) begin
      log_rd.push_back(pend_rd);
      log_data.push_back(pend_data);
      regs[pend_rd] = pend_data;
    end
  end

  typedef struct {
    int mv; int mrd; int md;
    int av; int ard; int ad;
    int hold; int rs1; int rs2;
    int e_mr; int e_ar; int e_we; int e_rd; int e_data; int e_cnt;
    int e_h1; int e_d1; int e_h2; int e_d2;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0; aluRd = '0; aluData = '0;
    memValid = 1'b0; memRd = '0; memData = '0;
    rfHold   = 1'b0; fwdRs1 = '0; fwdRs2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int l0;
  int n0;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 0;

    // mem(v,rd,d) alu(v,rd,d) hold rs1 rs2 | mr ar we rd data cnt h1 d1 h2 d2
    vt[0] = '{1,3,7,    1,4,9,    0, 3,4, 1,0,0, 0,0,   0, 0,0,    0,0};
    vt[1] = '{0,0,0,    1,4,9,    0, 3,4, 1,1,1, 3,7,   1, 1,7,    0,0};
    vt[2] = '{0,0,0,    0,0,0,    1, 4,3, 1,1,0, 4,9,   1, 1,9,    0,0};
    vt[3] = '{0,0,0,    1,0,'h55, 1, 4,0, 1,1,0, 4,9,   1, 1,9,    0,0};
    vt[4] = '{0,0,0,    1,4,'h11, 1, 4,0, 1,1,0, 4,9,   1, 1,9,    0,0};
    vt[5] = '{0,0,0,    0,0,0,    1, 4,0, 1,1,0, 4,9,   2, 1,'h11, 0,0};
    vt[6] = '{0,0,0,    0,0,0,    0, 4,9, 1,1,1, 4,9,   2, 1,'h11, 0,0};
    vt[7] = '{0,0,0,    0,0,0,    0, 4,3, 1,1,1, 4,'h11,1, 1,'h11, 0,0};
    vt[8] = '{0,0,0,    0,0,0,    0, 4,3, 1,1,0, 0,0,   0, 0,0,    0,0};

    // Reset state, with valids offered to show readys stay low.
    idle_inputs();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    memValid = 1'b1; aluValid = 1'b1; fwdRs1 = 5'd1; fwdRs2 = 5'd2;
    #1;
    chk("rst.memReady", int'(memReady), 0);
    chk("rst.aluReady", int'(aluReady), 0);
    chk("rst.we",       int'(rfWriteEnable), 0);
    chk("rst.rfRd",     int'(rfRd), 0);
    chk("rst.rfData",   int'(rfData), 0);
    chk("rst.count",    int'(count), 0);
    chk("rst.hit1",     int'(fwdHit1), 0);
    chk("rst.hit2",     int'(fwdHit2), 0);
    chk("rst.fwdData1", int'(fwdData1), 0);
    chk("rst.fwdData2", int'(fwdData2), 0);
    idle_inputs();
    resetN = 1'b1;
    tick();

    // 1. Reset mid-operation.
    rfHold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      aluValid = 1'b1; aluRd = 5'(i); aluData = 32'h30 + 32'(i);
      @(negedge clk);
      chk($sformatf("t1.aluReady%0d", i), int'(aluReady), 1);
      tick();
    end
    aluValid = 1'b0;
    rfHold   = 1'b0;
    @(negedge clk);
    chk("t1.count_full", int'(count), 3);
    chk("t1.we_before",  int'(rfWriteEnable), 1);
    l0 = log_rd.size();
    #1 resetN = 1'b0;
    #1;
    chk("t1.count_rst", int'(count), 0);
    chk("t1.we_rst",    int'(rfWriteEnable), 0);
    chk("t1.rfRd_rst",  int'(rfRd), 0);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    repeat (6) tick();
    chk("t1.no_writes", log_rd.size(), l0);
    chk("t1.count_end", int'(count), 0);

    // Table: contention, ordering, x0 drop, hold and forwarding.
    for (int i = 0; i < 9; i++) begin
      memValid = vt[i].mv != 0; memRd = 5'(vt[i].mrd); memData = 32'(vt[i].md);
      aluValid = vt[i].av != 0; aluRd = 5'(vt[i].ard); aluData = 32'(vt[i].ad);
      rfHold   = vt[i].hold != 0;
      fwdRs1   = 5'(vt[i].rs1); fwdRs2 = 5'(vt[i].rs2);
      @(negedge clk);
      chk($sformatf("v%0d.memReady", i), int'(memReady), vt[i].e_mr);
      chk($sformatf("v%0d.aluReady", i), int'(aluReady), vt[i].e_ar);
      chk($sformatf("v%0d.we", i),       int'(rfWriteEnable), vt[i].e_we);
      chk($sformatf("v%0d.rfRd", i),     int'(rfRd), vt[i].e_rd);
      chk($sformatf("v%0d.rfData", i),   int'(rfData), vt[i].e_data);
      chk($sformatf("v%0d.count", i),    int'(count), vt[i].e_cnt);
      chk($sformatf("v%0d.hit1", i),     int'(fwdHit1), vt[i].e_h1);
      chk($sformatf("v%0d.fwdData1", i), int'(fwdData1), vt[i].e_d1);
      chk($sformatf("v%0d.hit2", i),     int'(fwdHit2), vt[i].e_h2);
      chk($sformatf("v%0d.fwdData2", i), int'(fwdData2), vt[i].e_d2);
      tick();
    end
    idle_inputs();
    chk("tbl.nwrites", log_rd.size(), l0 + 3);
    if (log_rd.size() >= l0 + 3) begin
      chk("tbl.w0.rd", log_rd[l0], 3);     chk("tbl.w0.d", log_data[l0], 7);
      chk("tbl.w1.rd", log_rd[l0 + 1], 4); chk("tbl.w1.d", log_data[l0 + 1], 9);
      chk("tbl.w2.rd", log_rd[l0 + 2], 4); chk("tbl.w2.d", log_data[l0 + 2], 'h11);
    end

    // 2. Single ALU write.
    l0 = log_rd.size();
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2.aluReady", int'(aluReady), 1);
    tick();
    aluValid = 1'b0;
    @(negedge clk);
    chk("t2.we",     int'(rfWriteEnable), 1);
    chk("t2.rfRd",   int'(rfRd), 5);
    chk("t2.rfData", int'(rfData), 'hDEADBEEF);
    tick();
    chk("t2.nwrites", log_rd.size(), l0 + 1);
    chk("t2.R5",      regs[5], 'hDEADBEEF);

    // 4. Full and hold.
    l0 = log_rd.size();
    rfHold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      aluValid = 1'b1; aluRd = 5'(i); aluData = 32'h100 + 32'(i);
      @(negedge clk);
      chk($sformatf("t4.aluReady%0d", i), int'(aluReady), 1);
      tick();
    end
    aluRd = 5'd5; aluData = 32'h105;
    @(negedge clk);
    chk("t4.full.aluReady", int'(aluReady), 0);
    chk("t4.full.memReady", int'(memReady), 0);
    chk("t4.full.count",    int'(count), 4);
    chk("t4.full.we",       int'(rfWriteEnable), 0);
    tick();
    rfHold = 1'b0;
    @(negedge clk);
    chk("t4.rel.aluReady", int'(aluReady), 1);
    chk("t4.rel.we",       int'(rfWriteEnable), 1);
    chk("t4.rel.rfRd",     int'(rfRd), 1);
    tick();
    aluValid = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      chk($sformatf("t4.drain%0d.we", j),   int'(rfWriteEnable), 1);
      chk($sformatf("t4.drain%0d.rfRd", j), int'(rfRd), j);
      chk($sformatf("t4.drain%0d.data", j), int'(rfData), 'h100 + j);
      tick();
    end
    @(negedge clk);
    chk("t4.count_end", int'(count), 0);
    chk("t4.nwrites", log_rd.size(), l0 + 5);
    if (log_rd.size() >= l0 + 5) begin
      for (int j = 0; j < 5; j++) begin
        chk($sformatf("t4.order%0d", j), log_rd[l0 + j], j + 1);
      end
    end
    tick();

    // 5. x0 and forwarding.
    rfHold = 1'b1;
    aluValid = 1'b1; aluRd = 5'd0; aluData = 32'h55;
    @(negedge clk);
    chk("t5.x0.aluReady", int'(aluReady), 1);
    tick();
    aluRd = 5'd7; aluData = 32'd1;
    @(negedge clk);
    chk("t5.x0.count", int'(count), 0);
    tick();
    aluData = 32'd2;
    tick();
    aluValid = 1'b0;
    fwdRs1 = 5'd7; fwdRs2 = 5'd0;
    @(negedge clk);
    chk("t5.count",    int'(count), 2);
    chk("t5.hit1",     int'(fwdHit1), 1);
    chk("t5.fwdData1", int'(fwdData1), 2);
    chk("t5.hit2",     int'(fwdHit2), 0);
    chk("t5.fwdData2", int'(fwdData2), 0);
    tick();
    rfHold = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t5.count_end", int'(count), 0);
    chk("t5.R7", regs[7], 2);
    n0 = 0;
    foreach (log_rd[k]) if (log_rd[k] == 0) n0++;
    chk("t5.x0_writes", n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
